rx_symbol_aligner: RTL and testbench
====================================

RX_SYMBOL_ALIGNER -- requirements
Module: rx_symbol_aligner

Interface
REQ-001 SHALL have parameter CONFIRM_COMMAS, default 2: aligned K28.5 commas, including the first, needed to reach LOCKED.
REQ-002 SHALL have parameter CONFIRM_TIMEOUT, default 16: aligned symbols allowed in CHECK without a comma before returning to SEARCH.
REQ-003 SHALL have parameter MISALIGN_LIMIT, default 3: consecutive misaligned commas in LOCKED before returning to SEARCH.
REQ-004 Bit_Rate_Clk  in  1  serial bit clock; the single clock of the block.
REQ-005 Rst_n  in  1  reset; synchronous and active-low.
REQ-006 Ser_in  in  1  serial bit from PMA, one bit per clock, symbol bit a first.
REQ-007 RxPolarity  in  1  1 = invert Ser_in before use.
REQ-008 Symbol_Out  out  10  aligned symbol, bit 9 = a (first received), bit 0 = j.
REQ-009 Symbol_Valid  out  1  one-cycle strobe marking Symbol_Out valid.
REQ-010 Comma_Det  out  1  qualifies Symbol_Out as K28.5; meaningful only with Symbol_Valid.
REQ-011 Locked  out  1  high while state is LOCKED.
REQ-012 Align_Err  out  1  one-cycle pulse on each misaligned comma seen in LOCKED.

Function
REQ-013 Each clock SHALL shift (Ser_in XOR RxPolarity) into bit 0 of a 10-bit window, with older bits moving toward bit 9; a polarity change SHALL take effect on the next sampled bit.
REQ-014 Comma match SHALL be window == 10'b0011111010 (RD-) or 10'b1100000101 (RD+), evaluated combinationally on the registered window.
REQ-015 A phase counter (0..9, wrapping 9->0) SHALL define the boundary, boundary = (count == 9).
REQ-016 States SHALL be SEARCH, CHECK and LOCKED.
REQ-017 SEARCH, any comma match: the counter SHALL load 0, the confirm count SHALL load 1, and the state SHALL go to CHECK; if CONFIRM_COMMAS == 1, the state SHALL go directly to LOCKED.
REQ-018 CHECK, boundary with a comma: the confirm count SHALL increment; on reaching CONFIRM_COMMAS the state SHALL go to LOCKED.
REQ-019 CHECK, boundary without a comma: the timeout count SHALL increment; on reaching CONFIRM_TIMEOUT the state SHALL go to SEARCH.
REQ-020 CHECK: the timeout count SHALL clear on each aligned comma.
REQ-021 CHECK: a comma seen off-boundary SHALL be ignored.
REQ-022 LOCKED, at every boundary: in the following cycle, Symbol_Out SHALL equal the window, Symbol_Valid SHALL be 1 and Comma_Det SHALL equal the match result.
REQ-023 LOCKED, comma off-boundary: Align_Err SHALL pulse in the following cycle and the misalign count SHALL increment.
REQ-024 LOCKED: on reaching MISALIGN_LIMIT the state SHALL go to SEARCH, Locked SHALL drop, and the counter SHALL not be reloaded.
REQ-025 LOCKED: an aligned comma SHALL clear the misalign count.
REQ-026 The comma that completes confirmation SHALL itself be emitted, with Locked and Symbol_Valid rising in the same cycle.
REQ-027 Output latency SHALL be exactly one clock from the window holding a complete aligned symbol.
REQ-028 Symbol_Valid SHALL never assert outside LOCKED, except for the confirming comma in REQ-026.
REQ-029 Symbol_Valid pulses SHALL be spaced exactly 10 clocks apart while LOCKED.
REQ-030 Aligned comma and misaligned comma cannot coincide in one cycle; the boundary test SHALL take priority.
REQ-031 The counter SHALL wrap with no gap; counts SHALL saturate at their limits.

Reset
REQ-032 When Rst_n = 0 at a clock edge: window SHALL be 0, counter SHALL be 0, all counts SHALL be 0, state SHALL be SEARCH, Symbol_Out SHALL be 0, and Symbol_Valid, Comma_Det, Locked and Align_Err SHALL be 0.
REQ-033 Reset asserted mid-symbol or while LOCKED SHALL abort immediately, with no partial symbol emitted.
REQ-034 After release, the first comma match SHALL be possible 10 clocks later.

Structure
REQ-035 A shared package SHALL hold K28_5_RDN / K28_5_RDP constants, the state enum and the symbol width (10).
REQ-036 One sub-module comma_matcher (10-bit window in, match out, purely combinational) SHALL be used, so that PCS reuse is possible.

Verification
REQ-037 After reset, send 4x K28.5 alternating RD-/RD+, then D21.5 (1010101010) x8 -> Locked rises with the second comma's Symbol_Valid (Comma_Det=1); the next 8 strobes show 0x2AA, Comma_Det=0, 10 clocks apart.
REQ-038 Prefix 3 random bits before the REQ-037 stream -> identical symbols; alignment follows the comma, not reset.
REQ-039 RxPolarity=1 with the bit-inverted stream -> same Symbol_Out values as REQ-037.
REQ-040 Once LOCKED, insert a 1-bit slip, then repeat commas -> Align_Err pulses 3 times, Locked falls after the third, then relocks to the new phase after 2 aligned commas.
REQ-041 One comma, then 16 aligned D21.5 symbols -> returns to SEARCH; Locked never asserts; no Symbol_Valid.
REQ-042 Assert Rst_n=0 for 1 clock mid-symbol while LOCKED -> all outputs 0 on the next clock; no Symbol_Valid until re-confirmation.

Source files
------------

// File: rtl/rx_symbol_aligner_pkg.sv
// Shared definitions for the 8b/10b receive symbol aligner: symbol width,
// K28.5 comma codes, the alignment state enum and a saturating counter helper.
package rx_symbol_aligner_pkg;

  localparam int SYM_W = 10;
  localparam int CNT_W = 8;

  localparam logic [SYM_W-1:0] K28_5_RDN = 10'b0011111010;
  localparam logic [SYM_W-1:0] K28_5_RDP = 10'b1100000101;

  typedef enum logic [1:0] {
    ST_SEARCH = 2'd0,
    ST_CHECK  = 2'd1,
    ST_LOCKED = 2'd2
  } state_e;

  // Increment that sticks at the given limit instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic [CNT_W-1:0] lim);
    return (v >= lim) ? lim : v + 1'b1;
  endfunction

endpackage

// File: rtl/rx_symbol_aligner_comma_matcher.sv
// Combinational K28.5 detector, either running disparity, over a 10-bit window.
// Kept separate so the PCS can reuse it outside the aligner.
module comma_matcher
  import rx_symbol_aligner_pkg::*;
(
  input  logic [SYM_W-1:0] window_i,
  output logic             match_o
);

  assign match_o = (window_i == K28_5_RDN) || (window_i == K28_5_RDP);

endmodule

// File: rtl/rx_symbol_aligner.sv
// Serial-to-symbol aligner: shifts bits into a 10-bit window, hunts for K28.5,
// confirms the phase with repeated aligned commas, then emits one symbol every
// 10 clocks while watching for commas that have slipped off the boundary.
module rx_symbol_aligner
  import rx_symbol_aligner_pkg::*;
#(
  parameter int CONFIRM_COMMAS  = 2,
  parameter int CONFIRM_TIMEOUT = 16,
  parameter int MISALIGN_LIMIT  = 3
) (
  input  logic             Bit_Rate_Clk,
  input  logic             Rst_n,
  input  logic             Ser_in,
  input  logic             RxPolarity,
  output logic [SYM_W-1:0] Symbol_Out,
  output logic             Symbol_Valid,
  output logic             Comma_Det,
  output logic             Locked,
  output logic             Align_Err
);

  localparam logic [CNT_W-1:0] CONF_LIM = CNT_W'(CONFIRM_COMMAS);
  localparam logic [CNT_W-1:0] TO_LIM   = CNT_W'(CONFIRM_TIMEOUT);
  localparam logic [CNT_W-1:0] MIS_LIM  = CNT_W'(MISALIGN_LIMIT);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYM_W-1:0] win_q, win_d;
  logic [3:0]       phase_q, phase_d;
  logic [CNT_W-1:0] confirm_q, timeout_q, misalign_q;
  logic [CNT_W-1:0] confirm_inc, timeout_inc, misalign_inc;
  state_e           state_q;
  logic [SYM_W-1:0] sym_q;
  logic             vld_q, cd_q, lock_q, err_q;
  logic             match, boundary;

  // Newest bit enters at bit 0 so bit 9 ends up holding symbol bit a.
  assign win_d   = {win_q[SYM_W-2:0], Ser_in ^ RxPolarity};
  assign phase_d = (phase_q == 4'd9) ? 4'd0 : phase_q + 4'd1;
  assign boundary = (phase_q == 4'd9);

  assign confirm_inc  = sat_inc(confirm_q, CONF_LIM);
  assign timeout_inc  = sat_inc(timeout_q, TO_LIM);
  assign misalign_inc = sat_inc(misalign_q, MIS_LIM);

  comma_matcher u_comma_matcher (
    .window_i (win_q),
    .match_o  (match)
  );

  // Alignment FSM with registered symbol/strobe/status outputs.
  always_ff @(posedge Bit_Rate_Clk) begin
    if (!Rst_n) begin
      win_q      <= '0;
      phase_q    <= '0;
      confirm_q  <= '0;
      timeout_q  <= '0;
      misalign_q <= '0;
      state_q    <= ST_SEARCH;
      sym_q      <= '0;
      vld_q      <= 1'b0;
      cd_q       <= 1'b0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      win_q   <= win_d;
      phase_q <= phase_d;
      vld_q   <= 1'b0;
      cd_q    <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          // Any comma defines the phase: the window is complete right now,
          // so the next complete symbol lands when the counter reaches 9.
          if (match) begin
            phase_q    <= '0;
            confirm_q  <= CNT_ONE;
            timeout_q  <= '0;
            misalign_q <= '0;
            if (CONFIRM_COMMAS <= 1) begin
              state_q <= ST_LOCKED;
              lock_q  <= 1'b1;
              sym_q   <= win_q;
              vld_q   <= 1'b1;
              cd_q    <= 1'b1;
            end else begin
              state_q <= ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          // Off-boundary commas are deliberately ignored here.
          if (boundary) begin
            if (match) begin
              timeout_q <= '0;
              confirm_q <= confirm_inc;
              if (confirm_inc >= CONF_LIM) begin
                // The confirming comma is emitted as the first locked symbol.
                state_q    <= ST_LOCKED;
                lock_q     <= 1'b1;
                misalign_q <= '0;
                sym_q      <= win_q;
                vld_q      <= 1'b1;
                cd_q       <= 1'b1;
              end
            end else begin
              timeout_q <= timeout_inc;
              if (timeout_inc >= TO_LIM) begin
                state_q   <= ST_SEARCH;
                timeout_q <= '0;
              end
            end
          end
        end
        ST_LOCKED: begin
          if (boundary) begin
            sym_q <= win_q;
            vld_q <= 1'b1;
            cd_q  <= match;
            if (match) misalign_q <= '0;
          end else if (match) begin
            // Phase is kept on the way back to SEARCH; the next comma reloads it.
            err_q      <= 1'b1;
            misalign_q <= misalign_inc;
            if (misalign_inc >= MIS_LIM) begin
              state_q    <= ST_SEARCH;
              lock_q     <= 1'b0;
              misalign_q <= '0;
            end
          end
        end
        default: begin
          state_q <= ST_SEARCH;
          lock_q  <= 1'b0;
        end
      endcase
    end
  end

  assign Symbol_Out   = sym_q;
  assign Symbol_Valid = vld_q;
  assign Comma_Det    = cd_q;
  assign Locked       = lock_q;
  assign Align_Err    = err_q;

endmodule

// File: tb/tb_rx_symbol_aligner.sv
// Bench for rx_symbol_aligner: a bit-history model predicts every output cycle
// by cycle, and directed scenarios pin timing and values with literal numbers.
module tb_rx_symbol_aligner;

  localparam int CC = 2;
  localparam int TO = 16;
  localparam int ML = 3;

  localparam logic [9:0] RDN  = 10'b0011111010;
  localparam logic [9:0] RDP  = 10'b1100000101;
  localparam logic [9:0] D215 = 10'b1010101010;

  logic       clk = 1'b0;
  logic       Rst_n = 1'b0;
  logic       Ser_in = 1'b0;
  logic       RxPolarity = 1'b0;
  logic [9:0] Symbol_Out;
  logic       Symbol_Valid, Comma_Det, Locked, Align_Err;

  int checks = 0;
  int errors = 0;
  int edge_n = 0;

  rx_symbol_aligner #(
    .CONFIRM_COMMAS  (CC),
    .CONFIRM_TIMEOUT (TO),
    .MISALIGN_LIMIT  (ML)
  ) dut (
    .Bit_Rate_Clk (clk),
    .Rst_n        (Rst_n),
    .Ser_in       (Ser_in),
    .RxPolarity   (RxPolarity),
    .Symbol_Out   (Symbol_Out),
    .Symbol_Valid (Symbol_Valid),
    .Comma_Det    (Comma_Det),
    .Locked       (Locked),
    .Align_Err    (Align_Err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_n++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (edge %0d)", nm, act, exp, edge_n);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Works on the received bit history and edge indices: the symbol phase is the
  // edge at which the last comma was accepted ("anchor"); boundaries fall every
  // 10 edges after it.
  bit         model_ok = 1'b0;
  bit         hist[$];
  int         k, anchor, mode, conf, tmo, mis;
  logic [9:0] e_sym;
  logic       e_vld, e_cd, e_lock, e_err, e_rst;

  always @(posedge clk) begin
    logic [9:0] w;
    bit is_comma, on_b, emit;
    if (!Rst_n) begin
      hist.delete();
      k = 0; anchor = -1; mode = 0; conf = 0; tmo = 0; mis = 0;
      e_sym = '0; e_vld = 0; e_cd = 0; e_lock = 0; e_err = 0; e_rst = 1;
      model_ok = 1'b1;
    end else begin
      w = '0;
      for (int j = 0; j < 10; j++)
        if (hist.size() > j) w[j] = hist[hist.size()-1-j];
      is_comma = (w == RDN) || (w == RDP);
      on_b = ((k - anchor) % 10 == 0);
      emit = 0; e_vld = 0; e_cd = 0; e_err = 0; e_rst = 0;
      if (mode == 0) begin
        if (is_comma) begin
          anchor = k; conf = 1; tmo = 0; mis = 0;
          if (CC <= 1) begin mode = 2; emit = 1; end else mode = 1;
        end
      end else if (mode == 1) begin
        if (on_b && is_comma) begin
          tmo = 0; conf++;
          if (conf >= CC) begin mode = 2; mis = 0; emit = 1; end
        end else if (on_b) begin
          tmo++;
          if (tmo >= TO) begin mode = 0; tmo = 0; end
        end
      end else begin
        if (on_b) begin
          emit = 1;
          if (is_comma) mis = 0;
        end else if (is_comma) begin
          e_err = 1; mis++;
          if (mis >= ML) begin mode = 0; mis = 0; end
        end
      end
      if (emit) begin e_sym = w; e_vld = 1; e_cd = is_comma; end
      e_lock = (mode == 2);
      hist.push_back(Ser_in ^ RxPolarity);
      if (hist.size() > 10) void'(hist.pop_front());
      k++;
    end
  end

  // ---------------- per-cycle compare and event logs ----------------
  int         sv_edge[$];
  logic [9:0] sv_sym[$];
  logic       sv_cd[$];
  int         err_edge[$], rise_edge[$], fall_edge[$];
  logic       prev_lock = 1'b0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("valid", 32'(Symbol_Valid), 32'(e_vld));
      chk("locked", 32'(Locked), 32'(e_lock));
      chk("align_err", 32'(Align_Err), 32'(e_err));
      if (e_vld || e_rst) begin
        chk("symbol", 32'(Symbol_Out), 32'(e_sym));
        chk("comma_det", 32'(Comma_Det), 32'(e_cd));
      end
      if (Symbol_Valid === 1'b1) begin
        sv_edge.push_back(edge_n); sv_sym.push_back(Symbol_Out); sv_cd.push_back(Comma_Det);
      end
      if (Align_Err === 1'b1) err_edge.push_back(edge_n);
      if (Locked === 1'b1 && !prev_lock) rise_edge.push_back(edge_n);
      if (Locked !== 1'b1 && prev_lock) fall_edge.push_back(edge_n);
      prev_lock = (Locked === 1'b1);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_logs();
    sv_edge.delete(); sv_sym.delete(); sv_cd.delete();
    err_edge.delete(); rise_edge.delete(); fall_edge.delete();
  endtask

  task automatic send_bit(input logic b);
    Ser_in = b;
    @(negedge clk);
  endtask

  task automatic send_sym(input logic [9:0] s, input logic inv);
    for (int i = 9; i >= 0; i--) send_bit(s[i] ^ inv);
  endtask

  task automatic idle(input int n, input logic inv);
    for (int i = 0; i < n; i++) send_bit(inv);
  endtask

  task automatic do_reset();
    Rst_n = 1'b0;
    Ser_in = RxPolarity;
    @(negedge clk);
    Rst_n = 1'b1;
    @(negedge clk);
    clear_logs();
  endtask

  // 4 alternating commas then 8x D21.5, then idle.
  task automatic send_std(input logic inv, input int npre);
    logic [2:0] pre;
    pre = 3'b101;
    for (int i = 0; i < npre; i++) send_bit(pre[i]);
    send_sym(RDN, inv); send_sym(RDP, inv); send_sym(RDN, inv); send_sym(RDP, inv);
    for (int i = 0; i < 8; i++) send_sym(D215, inv);
    idle(20, inv);
  endtask

  task automatic check_std(input string tag, input int first_edge);
    logic [9:0] exp_s [11];
    for (int i = 0; i < 11; i++) exp_s[i] = D215;
    exp_s[0] = RDP; exp_s[1] = RDN; exp_s[2] = RDP;
    chk({tag, "_strobe_cnt_ge11"}, 32'(sv_edge.size() >= 11), 32'd1);
    if (sv_edge.size() >= 11) begin
      for (int i = 0; i < 11; i++) begin
        chk({tag, "_sym"}, 32'(sv_sym[i]), 32'(exp_s[i]));
        chk({tag, "_cd"}, 32'(sv_cd[i]), 32'(i < 3));
        if (i == 0) chk({tag, "_first_edge"}, sv_edge[0], first_edge);
        else        chk({tag, "_gap"}, sv_edge[i] - sv_edge[i-1], 32'd10);
      end
      chk({tag, "_lock_rises"}, rise_edge.size(), 32'd1);
      if (rise_edge.size() > 0) chk({tag, "_lock_with_strobe"}, rise_edge[0], sv_edge[0]);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog timeout at edge %0d", edge_n);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    repeat (2) @(negedge clk);

    // Lock and stream D21.5.
    do_reset();
    chk("reset_sym", 32'(Symbol_Out), 32'd0);
    chk("reset_locked", 32'(Locked), 32'd0);
    s0 = edge_n;
    send_std(1'b0, 0);
    check_std("basic", s0 + 21);

    // Three junk bits before the stream shift alignment by 3.
    do_reset();
    s0 = edge_n;
    send_std(1'b0, 3);
    check_std("prefix", s0 + 24);

    // Inverted line with polarity correction.
    RxPolarity = 1'b1;
    do_reset();
    s0 = edge_n;
    send_std(1'b1, 0);
    check_std("polarity", s0 + 21);
    RxPolarity = 1'b0;

    // One-bit slip while locked, then a run of commas.
    do_reset();
    send_sym(RDN, 1'b0); send_sym(RDP, 1'b0); send_sym(RDN, 1'b0); send_sym(RDP, 1'b0);
    clear_logs();
    send_bit(1'b0);
    for (int i = 0; i < 6; i++) send_sym((i % 2 == 0) ? RDN : RDP, 1'b0);
    idle(20, 1'b0);
    chk("slip_err_pulses", err_edge.size(), 32'd3);
    chk("slip_fall_cnt", fall_edge.size(), 32'd1);
    if (err_edge.size() == 3 && fall_edge.size() == 1) begin
      chk("slip_fall_at_third_err", fall_edge[0], err_edge[2]);
      chk("slip_err_gap", err_edge[1] - err_edge[0], 32'd10);
      chk("slip_relock_edge", rise_edge.size() > 0 ? rise_edge[0] - fall_edge[0] : -1, 32'd20);
    end
    chk("slip_relocked", 32'(Locked), 32'd1);

    // One comma then 16 aligned non-commas: timeout back to SEARCH.
    do_reset();
    send_sym(RDN, 1'b0);
    for (int i = 0; i < 16; i++) send_sym(D215, 1'b0);
    idle(2, 1'b0);
    chk("timeout_no_strobe", sv_edge.size(), 32'd0);
    chk("timeout_no_lock", rise_edge.size(), 32'd0);
    // A new phase must now be accepted, proving SEARCH was re-entered.
    idle(1, 1'b0);
    send_sym(RDP, 1'b0); send_sym(RDN, 1'b0);
    idle(3, 1'b0);
    chk("timeout_relock_newphase", 32'(Locked), 32'd1);

    // Reset pulse mid-symbol while locked.
    do_reset();
    send_sym(RDN, 1'b0); send_sym(RDP, 1'b0); send_sym(RDN, 1'b0); send_sym(RDP, 1'b0);
    send_sym(D215, 1'b0);
    for (int i = 9; i >= 5; i--) send_bit(D215[i]);
    chk("pre_reset_locked", 32'(Locked), 32'd1);
    Rst_n = 1'b0;
    send_bit(D215[4]);
    Rst_n = 1'b1;
    chk("midrst_sym", 32'(Symbol_Out), 32'd0);
    chk("midrst_vld", 32'(Symbol_Valid), 32'd0);
    chk("midrst_cd", 32'(Comma_Det), 32'd0);
    chk("midrst_lock", 32'(Locked), 32'd0);
    chk("midrst_err", 32'(Align_Err), 32'd0);
    clear_logs();
    for (int i = 3; i >= 0; i--) send_bit(D215[i]);
    for (int i = 0; i < 4; i++) send_sym(D215, 1'b0);
    chk("postrst_no_strobe", sv_edge.size(), 32'd0);
    chk("postrst_no_lock", 32'(Locked), 32'd0);

    idle(3, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
